// File: rtl/tiny_alu_pkg.sv
// Shared types and constants for the tiny ALU scheduler and its helpers.
package tiny_alu_pkg;

   localparam int OPCODE_BITS = 3;

   // Encodings 5..7 are reserved and answered with an error response.
   typedef enum logic [OPCODE_BITS-1:0] {
      OP_NO_OP = 3'd0,
      OP_ADD   = 3'd1,
      OP_AND   = 3'd2,
      OP_XOR   = 3'd3,
      OP_MUL   = 3'd4
   } opcode_e;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } sched_state_t;

endpackage

// File: rtl/tiny_alu_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above
// rr_ptr_i, wrapping modulo NUM_REQ. Reusable for any shared resource.
module tiny_alu_rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
   output logic [NUM_REQ-1:0]         grant_o,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
   output logic                       any_req_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   // Walk the requesters starting at the pointer and keep the first hit.
   always_comb begin
      int                cand;
      logic [IDX_W-1:0]  cand_idx;
      // NOTE: every output gets a default before the search, so paths that find no request cannot infer a latch.
      grant_o     = '0;
      grant_idx_o = '0;
      any_req_o   = 1'b0;
      cand        = 0;
      cand_idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(rr_ptr_i) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (!any_req_o && req_i[cand_idx]) begin
            any_req_o         = 1'b1;
            grant_o[cand_idx] = 1'b1;
            grant_idx_o       = cand_idx;
         end
      end
   end

endmodule

// File: rtl/tiny_alu_scheduler.sv
// Shares one multi-cycle ALU between NUM_REQ requesters: round-robin accept,
// drive and hold the ALU bus until done (or watchdog timeout), then return a
// one-cycle response to the requester that was served.
module tiny_alu_scheduler
   import tiny_alu_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int INPUT_DATA_BITS = 8,
   parameter int TIMEOUT_CYCLES  = 16
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NUM_REQ-1:0]                 req_valid_i,
   output logic [NUM_REQ-1:0]                 req_ready_o,
   input  logic [NUM_REQ*INPUT_DATA_BITS-1:0] req_a_i,
   input  logic [NUM_REQ*INPUT_DATA_BITS-1:0] req_b_i,
   input  logic [NUM_REQ*OPCODE_BITS-1:0]     req_opcode_i,
   output logic [NUM_REQ-1:0]                 rsp_valid_o,
   output logic [2*INPUT_DATA_BITS-1:0]       rsp_result_o,
   output logic                               rsp_error_o,
   output logic [INPUT_DATA_BITS-1:0]         alu_a_o,
   output logic [INPUT_DATA_BITS-1:0]         alu_b_o,
   output logic [OPCODE_BITS-1:0]             alu_opcode_o,
   output logic                               alu_start_o,
   input  logic [2*INPUT_DATA_BITS-1:0]       alu_result_i,
   input  logic                               alu_done_i
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int RES_W = 2 * INPUT_DATA_BITS;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_REQ - 1);

   sched_state_t                state_q, state_d;
   logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]            grant_idx_q, grant_idx_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [INPUT_DATA_BITS-1:0]  alu_a_q, alu_a_d;
   logic [INPUT_DATA_BITS-1:0]  alu_b_q, alu_b_d;
   logic [OPCODE_BITS-1:0]      alu_op_q, alu_op_d;
   logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
   logic [RES_W-1:0]            rsp_result_q, rsp_result_d;
   logic                        rsp_error_q, rsp_error_d;

   logic [NUM_REQ-1:0]          arb_grant;
   logic [IDX_W-1:0]            arb_idx;
   logic                        arb_any;
   logic [INPUT_DATA_BITS-1:0]  sel_a;
   logic [INPUT_DATA_BITS-1:0]  sel_b;
   logic [OPCODE_BITS-1:0]      sel_op;
   logic [NUM_REQ-1:0]          grant_onehot;
   logic [IDX_W-1:0]            next_ptr;

   tiny_alu_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arbiter (
      .req_i       (req_valid_i),
      .rr_ptr_i    (rr_ptr_q),
      .grant_o     (arb_grant),
      .grant_idx_o (arb_idx),
      .any_req_o   (arb_any)
   );

   assign sel_a        = req_a_i[arb_idx*INPUT_DATA_BITS +: INPUT_DATA_BITS];
   assign sel_b        = req_b_i[arb_idx*INPUT_DATA_BITS +: INPUT_DATA_BITS];
   assign sel_op       = req_opcode_i[arb_idx*OPCODE_BITS +: OPCODE_BITS];
   assign grant_onehot = NUM_REQ'(1) << grant_idx_q;
   assign next_ptr     = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;

   // Accept is combinational in IDLE and forced low while reset is held.
   assign req_ready_o  = (state_q == IDLE && !rst_i) ? arb_grant : '0;
   assign alu_start_o  = (state_q == BUSY);
   assign alu_a_o      = alu_a_q;
   assign alu_b_o      = alu_b_q;
   assign alu_opcode_o = alu_op_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_result_o = rsp_result_q;
   assign rsp_error_o  = rsp_error_q;

   // Next-state and next-output logic for the IDLE -> BUSY -> RESP sequence.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_idx_d  = grant_idx_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_error_d  = rsp_error_q;
      case (state_q)
         IDLE: begin
            if (arb_any) begin
               grant_idx_d = arb_idx;
               case (sel_op)
                  OP_ADD, OP_AND, OP_XOR, OP_MUL: begin
                     state_d  = BUSY;
                     cnt_d    = '0;
                     alu_a_d  = sel_a;
                     alu_b_d  = sel_b;
                     alu_op_d = sel_op;
                  end
                  OP_NO_OP: begin
                     state_d      = RESP;
                     rsp_valid_d  = arb_grant;
                     rsp_result_d = '0;
                     rsp_error_d  = 1'b0;
                  end
                  default: begin
                     state_d      = RESP;
                     rsp_valid_d  = arb_grant;
                     rsp_result_d = '0;
                     rsp_error_d  = 1'b1;
                  end
               endcase
            end
         end
         BUSY: begin
            cnt_d = cnt_q + 1'b1;
            // done wins over a watchdog expiry in the same cycle
            if (alu_done_i || cnt_q == TIMEOUT_LAST) begin
               state_d      = RESP;
               rsp_valid_d  = grant_onehot;
               rsp_result_d = alu_done_i ? alu_result_i : '0;
               rsp_error_d  = !alu_done_i;
               alu_a_d      = '0;
               alu_b_d      = '0;
               alu_op_d     = '0;
            end
         end
         RESP: begin
            state_d      = IDLE;
            rr_ptr_d     = next_ptr;
            cnt_d        = '0;
            rsp_valid_d  = '0;
            rsp_result_d = '0;
            rsp_error_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset abandons any operation in flight without a response.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         // NOTE: the latched operand registers are reset as well, because they drive the ALU bus directly and must read 0 out of reset.
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         grant_idx_q  <= '0;
         cnt_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         rsp_valid_q  <= '0;
         rsp_result_q <= '0;
         rsp_error_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_idx_q  <= grant_idx_d;
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_error_q  <= rsp_error_d;
      end
   end

endmodule

// File: tb/tb_tiny_alu_scheduler.sv
// Directed testbench for tiny_alu_scheduler with a small latency-programmable ALU model.
module tb_tiny_alu_scheduler;
   import tiny_alu_pkg::*;

   localparam int N = 4;
   localparam int W = 8;
   localparam int T = 16;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic [N-1:0]     req_valid_i = '0;
   logic [N-1:0]     req_ready_o;
   logic [N*W-1:0]   req_a_i = '0;
   logic [N*W-1:0]   req_b_i = '0;
   logic [N*3-1:0]   req_opcode_i = '0;
   logic [N-1:0]     rsp_valid_o;
   logic [2*W-1:0]   rsp_result_o;
   logic             rsp_error_o;
   logic [W-1:0]     alu_a_o;
   logic [W-1:0]     alu_b_o;
   logic [2:0]       alu_opcode_o;
   logic             alu_start_o;
   logic [2*W-1:0]   alu_result_i;
   logic             alu_done_i;

   int n_pass = 0;
   int n_checks = 0;

   // ALU model controls: done after alu_lat extra cycles of start; alu_en=0 hangs.
   int   alu_lat = 0;
   bit   alu_en = 1'b1;
   bit   alu_stray = 1'b0;
   logic [7:0] alu_cnt;

   tiny_alu_scheduler #(
      .NUM_REQ         (N),
      .INPUT_DATA_BITS (W),
      .TIMEOUT_CYCLES  (T)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_a_i      (req_a_i),
      .req_b_i      (req_b_i),
      .req_opcode_i (req_opcode_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_result_o (rsp_result_o),
      .rsp_error_o  (rsp_error_o),
      .alu_a_o      (alu_a_o),
      .alu_b_o      (alu_b_o),
      .alu_opcode_o (alu_opcode_o),
      .alu_start_o  (alu_start_o),
      .alu_result_i (alu_result_i),
      .alu_done_i   (alu_done_i)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i)            alu_cnt <= '0;
      else if (alu_start_o) alu_cnt <= alu_cnt + 8'd1;
      else                  alu_cnt <= '0;
   end

   function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd1:    return {8'h00, a} + {8'h00, b};
         3'd2:    return {8'h00, a & b};
         3'd3:    return {8'h00, a ^ b};
         3'd4:    return 16'(a) * 16'(b);
         default: return 16'hDEAD;
      endcase
   endfunction

   assign alu_done_i   = alu_stray || (alu_en && alu_start_o && (int'(alu_cnt) == alu_lat));
   assign alu_result_i = alu_fn(alu_opcode_o, alu_a_o, alu_b_o);

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic do_reset();
      rst_i = 1'b1;
      req_valid_i = '0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      req_a_i[k*W +: W]      = a;
      req_b_i[k*W +: W]      = b;
      req_opcode_i[k*3 +: 3] = op;
      req_valid_i[k]         = 1'b1;
   endtask

   // Step negedges after an accept until a response appears (bounded).
   task automatic collect(input int max_cycles, output int cyc, output int starts, output int rdy,
                          output logic [N-1:0] vld, output logic [15:0] res, output logic err, output bit seen);
      cyc = 0; starts = 0; rdy = 0; seen = 1'b0;
      vld = '0; res = '0; err = 1'b0;
      while (!seen && cyc < max_cycles) begin
         @(negedge clk_i);
         cyc++;
         if (alu_start_o) starts++;
         if (req_ready_o != '0) rdy++;
         if (rsp_valid_o != '0) begin
            seen = 1'b1;
            vld  = rsp_valid_o;
            res  = rsp_result_o;
            err  = rsp_error_o;
         end
      end
   endtask

   task automatic test_reset();
      req_valid_i = '1;
      @(negedge clk_i); #1;
      n_checks++;
      if (req_ready_o !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready_o); else n_pass++;
      n_checks++;
      if ({rsp_valid_o, rsp_result_o, rsp_error_o} !== 21'd0)
         $display("FAIL reset_rsp: got valid=%b result=%h err=%b want all 0", rsp_valid_o, rsp_result_o, rsp_error_o);
      else n_pass++;
      n_checks++;
      if ({alu_start_o, alu_a_o, alu_b_o, alu_opcode_o} !== 20'd0)
         $display("FAIL reset_alu_bus: got start=%b a=%h b=%h op=%0d want all 0", alu_start_o, alu_a_o, alu_b_o, alu_opcode_o);
      else n_pass++;
      req_valid_i = '0;
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      n_checks++;
      if ({req_ready_o, rsp_valid_o, alu_start_o} !== 9'd0)
         $display("FAIL idle_after_reset: got ready=%b valid=%b start=%b want 0", req_ready_o, rsp_valid_o, alu_start_o);
      else n_pass++;
   endtask

   task automatic test_single_add();
      int cyc, starts, rdy; logic [N-1:0] vld; logic [15:0] res; logic err; bit seen;
      alu_en = 1'b1; alu_lat = 1;
      set_req(2, 8'hFF, 8'h01, OP_ADD); #1;
      n_checks++;
      if (req_ready_o !== 4'b0100) $display("FAIL add_ready: got %b want 0100", req_ready_o); else n_pass++;
      @(negedge clk_i);
      n_checks++;
      if ({req_ready_o, alu_start_o, alu_a_o, alu_b_o, alu_opcode_o} !== {4'b0000, 1'b1, 8'hFF, 8'h01, 3'd1})
         $display("FAIL add_bus: got ready=%b start=%b a=%h b=%h op=%0d want 0000/1/ff/01/1",
                  req_ready_o, alu_start_o, alu_a_o, alu_b_o, alu_opcode_o);
      else n_pass++;
      collect(10, cyc, starts, rdy, vld, res, err, seen);
      n_checks++;
      if (!seen) $display("FAIL add_rsp_seen: no response within 10 cycles"); else n_pass++;
      n_checks++;
      if (cyc != 2 || starts != 1) $display("FAIL add_timing: got cyc=%0d starts=%0d want 2/1", cyc, starts); else n_pass++;
      n_checks++;
      if ({vld, res, err} !== {4'b0100, 16'h0100, 1'b0})
         $display("FAIL add_payload: got valid=%b result=%h err=%b want 0100/0100/0", vld, res, err);
      else n_pass++;
      req_valid_i = '0;
      @(negedge clk_i);
      n_checks++;
      if ({rsp_valid_o, alu_start_o, alu_a_o} !== 13'd0)
         $display("FAIL add_after: got valid=%b start=%b a=%h want 0", rsp_valid_o, alu_start_o, alu_a_o);
      else n_pass++;
   endtask

   task automatic test_stray_done();
      bit any = 1'b0;
      alu_stray = 1'b1;
      repeat (3) begin
         @(negedge clk_i);
         if (rsp_valid_o != '0 || alu_start_o) any = 1'b1;
      end
      alu_stray = 1'b0;
      n_checks++;
      if (any) $display("FAIL stray_done: got activity=1 want 0"); else n_pass++;
   endtask

   task automatic test_round_robin();
      int cyc, starts, rdy; logic [N-1:0] vld; logic [15:0] res; logic err; bit seen;
      logic [15:0] exp_res [4] = '{16'h0002, 16'h0006, 16'h000C, 16'h0014};
      logic [N-1:0] exp_g;
      do_reset();
      alu_en = 1'b1; alu_lat = 2;
      for (int k = 0; k < N; k++) set_req(k, 8'(k + 1), 8'(k + 2), OP_MUL);
      #1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk_i);
         exp_g = N'(1) << (i % N);
         n_checks++;
         if (req_ready_o !== exp_g) $display("FAIL rr_ready_%0d: got %b want %b", i, req_ready_o, exp_g); else n_pass++;
         collect(20, cyc, starts, rdy, vld, res, err, seen);
         n_checks++;
         if (!seen || cyc != 4 || starts != 3 || rdy != 0)
            $display("FAIL rr_timing_%0d: got seen=%0d cyc=%0d starts=%0d ready_cycles=%0d want 1/4/3/0", i, seen, cyc, starts, rdy);
         else n_pass++;
         n_checks++;
         if ({vld, res, err} !== {exp_g, exp_res[i % N], 1'b0})
            $display("FAIL rr_payload_%0d: got valid=%b result=%h err=%b want %b/%h/0", i, vld, res, err, exp_g, exp_res[i % N]);
         else n_pass++;
      end
      req_valid_i = '0;
      @(negedge clk_i);
   endtask

   task automatic test_noop_illegal();
      int cyc, starts, rdy; logic [N-1:0] vld; logic [15:0] res; logic err; bit seen;
      logic [2:0] ops [3]  = '{3'd0, 3'd5, 3'd7};
      logic       errs [3] = '{1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
         set_req(1, 8'h12, 8'h34, ops[i]); #1;
         n_checks++;
         if (req_ready_o !== 4'b0010) $display("FAIL op%0d_ready: got %b want 0010", ops[i], req_ready_o); else n_pass++;
         collect(5, cyc, starts, rdy, vld, res, err, seen);
         n_checks++;
         if (!seen || cyc != 1 || starts != 0)
            $display("FAIL op%0d_timing: got seen=%0d cyc=%0d starts=%0d want 1/1/0", ops[i], seen, cyc, starts);
         else n_pass++;
         n_checks++;
         if ({vld, res, err} !== {4'b0010, 16'h0000, errs[i]})
            $display("FAIL op%0d_payload: got valid=%b result=%h err=%b want 0010/0000/%b", ops[i], vld, res, err, errs[i]);
         else n_pass++;
         req_valid_i = '0;
         @(negedge clk_i);
      end
   endtask

   task automatic test_timeout();
      int cyc, starts, rdy; logic [N-1:0] vld; logic [15:0] res; logic err; bit seen;
      alu_en = 1'b0;
      set_req(3, 8'h10, 8'h20, OP_ADD); #1;
      n_checks++;
      if (req_ready_o !== 4'b1000) $display("FAIL to_ready: got %b want 1000", req_ready_o); else n_pass++;
      collect(40, cyc, starts, rdy, vld, res, err, seen);
      n_checks++;
      if (!seen || cyc != T + 1 || starts != T)
         $display("FAIL to_timing: got seen=%0d cyc=%0d starts=%0d want 1/17/16", seen, cyc, starts);
      else n_pass++;
      n_checks++;
      if ({vld, res, err} !== {4'b1000, 16'h0000, 1'b1})
         $display("FAIL to_payload: got valid=%b result=%h err=%b want 1000/0000/1", vld, res, err);
      else n_pass++;
      req_valid_i = '0;
      @(negedge clk_i);
      alu_en = 1'b1; alu_lat = 0;
      set_req(0, 8'hF0, 8'h3C, OP_XOR); #1;
      collect(10, cyc, starts, rdy, vld, res, err, seen);
      n_checks++;
      if (!seen || cyc != 2 || starts != 1)
         $display("FAIL after_to_timing: got seen=%0d cyc=%0d starts=%0d want 1/2/1", seen, cyc, starts);
      else n_pass++;
      n_checks++;
      if ({vld, res, err} !== {4'b0001, 16'h00CC, 1'b0})
         $display("FAIL after_to_payload: got valid=%b result=%h err=%b want 0001/00cc/0", vld, res, err);
      else n_pass++;
      req_valid_i = '0;
      @(negedge clk_i);
   endtask

   task automatic test_done_timeout_coincide();
      int cyc, starts, rdy; logic [N-1:0] vld; logic [15:0] res; logic err; bit seen;
      alu_en = 1'b1; alu_lat = T - 1;
      set_req(1, 8'hFF, 8'hFF, OP_MUL); #1;
      collect(40, cyc, starts, rdy, vld, res, err, seen);
      n_checks++;
      if (!seen || cyc != T + 1 || starts != T)
         $display("FAIL coincide_timing: got seen=%0d cyc=%0d starts=%0d want 1/17/16", seen, cyc, starts);
      else n_pass++;
      n_checks++;
      if ({vld, res, err} !== {4'b0010, 16'hFE01, 1'b0})
         $display("FAIL coincide_payload: got valid=%b result=%h err=%b want 0010/fe01/0", vld, res, err);
      else n_pass++;
      req_valid_i = '0;
      @(negedge clk_i);
   endtask

   task automatic test_reset_mid_op();
      int cyc, starts, rdy; logic [N-1:0] vld; logic [15:0] res; logic err; bit seen;
      bit any = 1'b0;
      alu_en = 1'b1; alu_lat = 2;
      set_req(2, 8'h03, 8'h05, OP_MUL); #1;
      n_checks++;
      if (req_ready_o !== 4'b0100) $display("FAIL rst_mid_ready: got %b want 0100", req_ready_o); else n_pass++;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1; #1;
      n_checks++;
      if ({req_ready_o, rsp_valid_o, alu_start_o, alu_a_o, alu_b_o, alu_opcode_o, rsp_result_o, rsp_error_o} !== 45'd0)
         $display("FAIL rst_mid_outputs: got ready=%b valid=%b start=%b a=%h b=%h op=%0d result=%h err=%b want all 0",
                  req_ready_o, rsp_valid_o, alu_start_o, alu_a_o, alu_b_o, alu_opcode_o, rsp_result_o, rsp_error_o);
      else n_pass++;
      repeat (3) begin
         @(negedge clk_i);
         if (rsp_valid_o != '0) any = 1'b1;
      end
      n_checks++;
      if (any) $display("FAIL rst_mid_no_rsp: got response during reset want none"); else n_pass++;
      set_req(0, 8'h07, 8'h09, OP_MUL);
      set_req(1, 8'h02, 8'h02, OP_ADD);
      rst_i = 1'b0; #1;
      n_checks++;
      if (req_ready_o !== 4'b0001) $display("FAIL rst_mid_next_grant: got %b want 0001", req_ready_o); else n_pass++;
      collect(20, cyc, starts, rdy, vld, res, err, seen);
      n_checks++;
      if ({seen, vld, res, err} !== {1'b1, 4'b0001, 16'h003F, 1'b0})
         $display("FAIL rst_mid_next_payload: got seen=%0d valid=%b result=%h err=%b want 1/0001/003f/0", seen, vld, res, err);
      else n_pass++;
      req_valid_i = '0;
      @(negedge clk_i);
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_stray_done();
      test_round_robin();
      test_noop_illegal();
      test_timeout();
      test_done_timeout_coincide();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tiny_alu_scheduler.md
Name: tiny_alu_scheduler

Overview:
- Shares one tiny ALU between NUM_REQ independent requesters.
- Each requester presents an operation (a, b, opcode) with a valid/ready handshake.
- Round-robin arbitration; drives the ALU start/opcode/operand bus and holds start until done.
- Returns a one-cycle response (result, error) to the granted requester, plus a timeout watchdog on a hung ALU.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- INPUT_DATA_BITS, 8, operand width; result width is 2*INPUT_DATA_BITS.
- TIMEOUT_CYCLES, 16, maximum cycles start may be held without done before an error response.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a_i  in  NUM_REQ*INPUT_DATA_BITS  packed operand A; requester k occupies slice k.
- req_b_i  in  NUM_REQ*INPUT_DATA_BITS  packed operand B.
- req_opcode_i  in  NUM_REQ*OPCODE_BITS  packed opcode.
- rsp_valid_o  out  NUM_REQ  one-hot response strobe.
- rsp_result_o  out  2*INPUT_DATA_BITS  result, shared by all requesters, qualified by rsp_valid_o.
- rsp_error_o  out  1  error flag, qualified by rsp_valid_o.
- alu_a_o  out  INPUT_DATA_BITS  to ALU a_i.
- alu_b_o  out  INPUT_DATA_BITS  to ALU b_i.
- alu_opcode_o  out  OPCODE_BITS  to ALU opcode_i.
- alu_start_o  out  1  to ALU start_i.
- alu_result_i  in  2*INPUT_DATA_BITS  from ALU result_o.
- alu_done_i  in  1  from ALU done_o.

Behaviour:
- Clocking and reset: single clock clk_i; rst_i is asynchronous and active-high.
- Reset values: every output is 0; FSM is IDLE; rr_ptr=0; timeout counter=0; latched operands=0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any req_valid_i is set, grant the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Assert req_ready_o[g] combinationally in that same cycle; the handshake completes on that edge.
  - Latch g, a, b and opcode.
  - Opcode ADD/AND/XOR/MUL -> BUSY.
  - Opcode NO_OP -> RESP with result 0, error 0; the ALU is not started.
  - Opcode in the unused range (5..7) -> RESP with result 0, error 1; the ALU is not started.
- BUSY:
  - alu_start_o=1; alu_a_o, alu_b_o and alu_opcode_o are driven from registers and held stable.
  - Timeout counter increments each cycle.
  - On alu_done_i=1: latch alu_result_i, error 0, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES with no done: result 0, error 1, go to RESP.
  - done takes priority if it coincides with timeout.
- RESP:
  - rsp_valid_o[g]=1 for exactly one cycle; alu_start_o=0.
  - rr_ptr <= (g+1) mod NUM_REQ; counter cleared; go to IDLE.
- Idle ALU bus: alu_start_o=0 and the ALU operand/opcode outputs hold 0 outside BUSY.
- Ready/response timing:
  - req_ready_o is 0 in BUSY and RESP.
  - Minimum request-to-request spacing is 3 cycles (IDLE, BUSY>=1, RESP).
  - NO_OP and illegal opcodes take 2 cycles.
- alu_done_i outside BUSY is ignored.
- A requester may drop req_valid_i before it is accepted without any effect.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0, no response emitted, rr_ptr back to 0.
- Widths: the result is passed through unmodified with no truncation; the operand slice for requester k is bits [k*W +: W].

Decomposition:
- tiny_alu_pkg (shared) holds:
  - OPCODE_BITS = 3.
  - Opcode enum: NO_OP=0, ADD=1, AND=2, XOR=3, MUL=4.
  - State enum sched_state_t {IDLE, BUSY, RESP}.
- Sub-module tiny_alu_rr_arbiter:
  - Parameter NUM_REQ; inputs req vector and rr_ptr.
  - Outputs one-hot grant, grant index and any_req.
  - Purely combinational, reusable for other shared resources.

Test Plan:
1. Single ADD: requester 2, a=0xFF, b=0x01, ALU model asserts done 1 cycle after start -> req_ready_o=4'b0100 for 1 cycle; start held until done; rsp_valid_o=4'b0100, rsp_result_o=0x0100, error 0.
2. Round-robin: all four valid with MUL (3-cycle done) from reset -> grant order 0,1,2,3,0; each accept only after the prior RESP; results 0x0002, 0x0006, 0x000C, 0x0014 for a=k+1, b=k+2.
3. NO_OP and illegal opcode 7 from requester 1 -> no alu_start_o; response 2 cycles after accept; result 0; error 0 for NO_OP, error 1 for opcode 7.
4. Timeout: ALU model never asserts done, TIMEOUT_CYCLES=16 -> start high for 16 cycles, then rsp_valid_o pulse with error 1; next request is served normally.
5. Reset mid-MUL: assert rst_i in the second BUSY cycle -> all outputs 0 asynchronously, no rsp_valid_o; after release the next grant goes to requester 0.
6. Coincident done and timeout on the same cycle -> error 0 and ALU result returned.
